// File: rtl/eq_band_scheduler.sv
// Sequences the shared biquad MAC across NBANDS bands per audio sample and
// arbitrates the coefficient port between host writes and band computations.
module eq_band_scheduler #(
  parameter int largo   = 25,
  parameter int NBANDS  = 3,
  parameter int MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [largo-1:0] data_i,
  output logic                    sample_ready,
  output logic signed [largo-1:0] x_o,
  output logic [1:0]              band_o,
  output logic [2:0]              step_o,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    wb_o,
  output logic                    sample_done,
  output logic                    overrun,
  input  logic                    ovr_clr,
  input  logic                    cfg_req,
  output logic                    cfg_gnt,
  input  logic                    cfg_done
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_WAIT, S_WB, S_DONE, S_CFG} state_t;

  localparam logic [1:0] LAST_BAND = 2'(NBANDS - 1);
  localparam logic [2:0] LAST_STEP = 3'd4;
  // Only reachable when MAC_LAT > 0, so the wrapped value for 0 is never used.
  localparam logic [2:0] LAST_WAIT = 3'(MAC_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;

  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    wb_o         = 1'b0;
    sample_done  = 1'b0;
    cfg_gnt      = 1'b0;
    case (state)
      S_IDLE: begin
        sample_ready = 1'b1;
        // A coincident sample wins; the level-held cfg_req is serviced later.
        if (sample_valid)  state_nxt = S_MAC;
        else if (cfg_req)  state_nxt = S_CFG;
      end
      S_MAC: begin
        mac_en  = 1'b1;
        mac_clr = (step_o == 3'd0);
        if (step_o == LAST_STEP) state_nxt = (MAC_LAT == 0) ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == LAST_WAIT) state_nxt = S_WB;
      end
      S_WB: begin
        wb_o      = 1'b1;
        state_nxt = (band_o == LAST_BAND) ? S_DONE : S_MAC;
      end
      S_DONE: begin
        sample_done = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_CFG: begin
        cfg_gnt = 1'b1;
        if (cfg_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      x_o      <= '0;
      band_o   <= '0;
      step_o   <= '0;
      wait_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sample_valid && state != S_IDLE) overrun <= 1'b1;
      else if (ovr_clr)                    overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            x_o    <= data_i;
            band_o <= '0;
            step_o <= '0;
          end
        end
        S_MAC: begin
          if (step_o != LAST_STEP) step_o <= step_o + 3'd1;
          wait_cnt <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 3'd1;
        S_WB: begin
          if (band_o != LAST_BAND) begin
            band_o <= band_o + 2'd1;
            step_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/eq_band_scheduler.md
# eq_band_scheduler

Time-multiplexes the single shared biquad MAC datapath of the audio equalizer across `NBANDS` filter bands for each incoming audio sample. It captures the sample, then sequences each band through its five MAC steps. It waits out the MAC pipeline and strobes the band's delay-line write-back. It also arbitrates the coefficient-configuration port so host coefficient writes never overlap a band computation. It sits between the audio sample source and the filter datapath/coefficient RAM.

## Interface
- `largo`, 25: sample width in bits (signed).
- `NBANDS`, 3: number of bands; legal range 1..4.
- `MAC_LAT`, 2: MAC pipeline latency in cycles after the last `mac_en`; legal range 0..7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_valid` in 1: new sample on `data_i`; a one-cycle strobe.
- `data_i` in `largo`: signed input sample.
- `sample_ready` out 1: scheduler is idle and can accept a sample.
- `x_o` out `largo`: latched current sample, driven to the datapath.
- `band_o` out 2: band currently being processed.
- `step_o` out 3: MAC step 0..4, selecting b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2.
- `mac_clr` out 1: clear the accumulator; asserted with step 0.
- `mac_en` out 1: MAC accumulate enable.
- `wb_o` out 1: write-back strobe; the datapath shifts band `band_o`'s delay line.
- `sample_done` out 1: one-cycle pulse when all bands are finished.
- `overrun` out 1: sticky flag; a sample arrived while not ready.
- `ovr_clr` in 1: clears `overrun`.
- `cfg_req` in 1: host requests the coefficient port.
- `cfg_gnt` out 1: coefficient port granted to the host.
- `cfg_done` in 1: host releases the port.

## Operation
- States: IDLE, MAC, WAIT, WB, DONE, CFG.
- All outputs are registered or Moore-decoded from state.
- IDLE:
  - `sample_ready`=1.
  - If `sample_valid`: latch `data_i` into `x_o`, set band=0 and step=0, go to MAC.
  - Else if `cfg_req`: go to CFG.
  - If `sample_valid` and `cfg_req` arrive in the same cycle, the sample wins and the request stays pending.
- MAC:
  - `mac_en`=1, `step_o`=step; `mac_clr`=1 only at step 0.
  - Step increments each cycle. After step 4, go to WAIT, or straight to WB if `MAC_LAT`=0.
- WAIT:
  - Counts `MAC_LAT` cycles with `mac_en`=0, then goes to WB.
- WB:
  - `wb_o`=1 for exactly one cycle.
  - If band==NBANDS−1, go to DONE. Else band+1, step=0, go to MAC.
- DONE:
  - `sample_done`=1 for one cycle, then go to IDLE.
- CFG:
  - `cfg_gnt`=1 and `sample_ready`=0. Stay until `cfg_done`, then go to IDLE.
  - `cfg_gnt` drops on the cycle after `cfg_done` is sampled.
- Overrun:
  - `sample_valid` in any state other than IDLE sets `overrun`=1. The sample is dropped; `x_o` and the sequence are unaffected.
  - `ovr_clr` clears the flag. If a set and a clear coincide, the set wins.
- `band_o` and `step_o` hold their last values outside MAC/WAIT/WB. They are only meaningful when `mac_en` or `wb_o` is high.
- `x_o` is stable from the capture edge until the next accepted sample.

## Timing
- Reset values: state IDLE, `sample_ready`=1, and 0 on `x_o`, `band_o`, `step_o`, `mac_clr`, `mac_en`, `wb_o`, `sample_done`, `overrun`, `cfg_gnt`.
- Reset mid-operation aborts the sequence immediately. No `wb_o` or `sample_done` is issued for the aborted sample.
- Sample accepted in cycle T (IDLE and `sample_valid`):
  - MAC steps 0..4 occupy T+1..T+5.
  - WAIT occupies T+6..T+5+`MAC_LAT`.
  - WB falls at T+6+`MAC_LAT`.
- Per-band period is 6+`MAC_LAT` cycles.
- `sample_done` rises at T+1+NBANDS·(6+`MAC_LAT`). `sample_ready` returns the following cycle.
- Defaults: `sample_done` at T+25, ready at T+26. At 48 kHz the sample period must exceed this.
- `cfg_req` taken in IDLE at cycle C gives `cfg_gnt`=1 from C+1.
- `cfg_req` arriving during a computation is serviced in the first IDLE cycle after DONE, unless a new `sample_valid` arrives in that same cycle.

## Test plan
- Reset, then one sample `data_i`=25'h0000123 at T, defaults:
  - `x_o`=0x123 from T+1.
  - `mac_clr` high at T+1, T+9, T+17.
  - `wb_o` at T+8, T+16, T+24 with `band_o` 0, 1, 2.
  - `sample_done` at T+25, `sample_ready` at T+26.
- `MAC_LAT`=0, NBANDS=1:
  - Steps at T+1..T+5, `wb_o` at T+6, `sample_done` at T+7.
  - Next sample accepted at T+8.
- Second `sample_valid` at T+10:
  - `overrun`=1 from T+11, `x_o` unchanged, schedule unchanged.
  - `ovr_clr` at T+30 clears `overrun` at T+31.
- `cfg_req` and `sample_valid` together in IDLE:
  - Sample sequence runs first.
  - `cfg_gnt` rises the cycle after `sample_done`+1 (first IDLE cycle) and drops one cycle after `cfg_done`.
- `sample_valid` during CFG sets `overrun` and is dropped. No `mac_en` appears until after `cfg_gnt` falls.
- `rst` asserted at T+12 mid-band-1:
  - All outputs are at reset values next cycle, and no `sample_done` is issued.
  - A fresh sample afterwards starts at band 0.
